// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide unit: operation select codes,
// control FSM states, iteration count and the operand magnitude helper.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam int         ITER_COUNT = 32;
  localparam logic [4:0] ITER_LAST  = 5'(ITER_COUNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Magnitude as an unsigned 32-bit value; 0x80000000 maps to 2^31 unchanged.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_divider.sv
// Restoring divider datapath: one quotient bit per step on unsigned magnitudes.
// The post-step quotient/remainder are also exposed so the caller can capture
// the final answer on the same edge that performs the last step.
module muldiv_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quo_next,
  output logic [31:0] rem_next
);

  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvs_q, dvs_d;
  logic [32:0] shifted;
  logic [32:0] diff;

  // Trial subtraction: keep the difference when it does not go negative.
  always_comb begin
    shifted = {rem_q, quo_q[31]};
    diff    = shifted - {1'b0, dvs_q};
    if (!diff[32]) begin
      rem_next = diff[31:0];
      quo_next = {quo_q[30:0], 1'b1};
    end else begin
      rem_next = shifted[31:0];
      quo_next = {quo_q[30:0], 1'b0};
    end
  end

  // Load operands on request, otherwise advance one bit per step.
  always_comb begin
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    if (load) begin
      quo_d = dividend;
      rem_d = 32'd0;
      dvs_d = divisor;
    end else if (step) begin
      quo_d = quo_next;
      rem_d = rem_next;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q <= 32'd0;
      rem_q <= 32'd0;
      dvs_q <= 32'd0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with sign handling and control FSM.
// Build option MULDIV_FAST_MUL_EN: multiplies complete in one cycle through a
// 33x33 signed product (IDLE -> DONE); divides are unaffected.
//
// state   | meaning
// IDLE    | waiting for start; operands latched on acceptance
// MUL     | shift-add multiply, one multiplier bit per cycle
// DIV     | restoring divide, one quotient bit per cycle
// DONE    | one-cycle done pulse, result valid; start ignored
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] op1_q, op1_d;
  logic        s1_q, s1_d, s2_q, s2_d, dvz_q, dvz_d;
  logic [63:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] result_q, result_d;

  logic        op1_signed, op2_signed;
  logic [31:0] mag1, mag2;
  logic [63:0] acc_step, mul_fixed;
  logic [31:0] mul_res, div_res;
  logic        div_load, div_step;
  logic [31:0] quo_next, rem_next;

  muldiv_divider u_divider (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .step     (div_step),
    .dividend (mag1),
    .divisor  (mag2),
    .quo_next (quo_next),
    .rem_next (rem_next)
  );

  // Operand signedness and magnitudes of the incoming request.
  always_comb begin
    op1_signed = (funct3 != F3_MULHU) && (funct3 != F3_DIVU) && (funct3 != F3_REMU);
    op2_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH) ||
                 (funct3 == F3_DIV) || (funct3 == F3_REM);
    mag1 = mag32(op1, op1_signed);
    mag2 = mag32(op2, op2_signed);
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [32:0] fast_a, fast_b;
  logic signed [65:0] fast_prod;
  logic [31:0]        fast_res;

  // Single-cycle product of sign- or zero-extended operands.
  always_comb begin
    fast_a    = {op1_signed & op1[31], op1};
    fast_b    = {op2_signed & op2[31], op2};
    fast_prod = fast_a * fast_b;
    fast_res  = (funct3 == F3_MUL) ? fast_prod[31:0] : fast_prod[63:32];
  end
`endif

  // Final-step values with sign correction and divide special cases.
  always_comb begin
    acc_step  = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
    mul_fixed = (s1_q ^ s2_q) ? (~acc_step + 64'd1) : acc_step;
    mul_res   = (funct3_q == F3_MUL) ? mul_fixed[31:0] : mul_fixed[63:32];
    if (dvz_q) begin
      div_res = funct3_q[1] ? op1_q : 32'hFFFF_FFFF;
    end else if (funct3_q[1]) begin
      div_res = s1_q ? (~rem_next + 32'd1) : rem_next;
    end else begin
      div_res = (s1_q ^ s2_q) ? (~quo_next + 32'd1) : quo_next;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    funct3_d = funct3_q;
    op1_d    = op1_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    dvz_d    = dvz_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    result_d = result_q;
    div_load = 1'b0;
    div_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          funct3_d = funct3;
          op1_d    = op1;
          s1_d     = op1_signed & op1[31];
          s2_d     = op2_signed & op2[31];
          dvz_d    = (op2 == 32'd0);
          cnt_d    = ITER_LAST;
          if (funct3[2]) begin
            state_d  = ST_DIV;
            div_load = 1'b1;
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            state_d  = ST_DONE;
            result_d = fast_res;
`else
            state_d  = ST_MUL;
            acc_d    = 64'd0;
            mcand_d  = {32'd0, mag1};
            mplier_d = mag2;
`endif
          end
        end
      end
      ST_MUL: begin
        acc_d    = acc_step;
        mcand_d  = {mcand_q[62:0], 1'b0};
        mplier_d = {1'b0, mplier_q[31:1]};
        cnt_d    = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          state_d  = ST_DONE;
          result_d = mul_res;
        end
      end
      ST_DIV: begin
        div_step = 1'b1;
        cnt_d    = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          state_d  = ST_DONE;
          result_d = div_res;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 5'd0;
      funct3_q <= 3'd0;
      op1_q    <= 32'd0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      dvz_q    <= 1'b0;
      acc_q    <= 64'd0;
      mcand_q  <= 64'd0;
      mplier_q <= 32'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      funct3_q <= funct3_d;
      op1_q    <= op1_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      dvz_q    <= dvz_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == ST_MUL) || (state_q == ST_DIV);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  muldiv_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .op1    (op1),
    .op2    (op2),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V M-extension semantics from 64-bit arithmetic.
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint     sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'($signed(a) / $signed(b));
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'($signed(a) % $signed(b));
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // mode 0: quiet inputs; 1: start held high (random operands) through DONE;
  // 2: extra start pulse a few cycles into the operation.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int mode);
    int          done_at   = 0;
    int          busy_cnt  = 0;
    int          overlap   = 0;
    int          exp_lat   = 33;
    int          exp_busy  = 32;
    logic [31:0] res_done  = 32'd0;
`ifdef MULDIV_FAST_MUL_EN
    if (!f[2]) begin
      exp_lat  = 1;
      exp_busy = 0;
    end
`endif
    @(negedge clk);
    start  = 1'b1;
    funct3 = f;
    op1    = a;
    op2    = b;
    @(posedge clk);
    #1;
    start  = (mode == 1);
    funct3 = 3'($urandom);
    op1    = $urandom;
    op2    = $urandom;
    for (int c = 1; c <= 40 && done_at == 0; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (busy && done) overlap++;
      if (done) begin
        done_at  = c;
        res_done = result;
      end
      if (mode == 1) begin
        funct3 = 3'($urandom);
        op1    = $urandom;
        op2    = $urandom;
      end
      if (mode == 2 && c == 4) begin
        start  = 1'b1;
        funct3 = 3'd4;
        op1    = 32'd999;
        op2    = 32'd3;
      end
      if (mode == 2 && c == 5) start = 1'b0;
    end
    chk({tag, " latency"}, 32'(done_at), 32'(exp_lat));
    chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
    chk({tag, " busy_done_overlap"}, 32'(overlap), 32'd0);
    chk({tag, " result"}, res_done, exp);
    @(negedge clk);
    start = 1'b0;
    chk({tag, " idle_after_done"}, {30'd0, busy, done}, 32'd0);
    chk({tag, " result_held"}, result, exp);
  endtask

  initial begin
    int          seen;
    logic [2:0]  f;
    logic [31:0] a, b;

    rst    = 1'b1;
    start  = 1'b0;
    funct3 = 3'd0;
    op1    = 32'd0;
    op2    = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset result", result, 32'd0);
    rst = 1'b0;

    run_op("mul_7x6",       3'd0, 32'd7,          32'd6,          32'h0000_002A, 0);
    run_op("mulh_m1",       3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000, 0);
    run_op("mulhu_m1",      3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 0);
    run_op("mulhsu_m1",     3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 1);
    run_op("div_m7_m3",     3'd4, 32'hFFFF_FFF9,  32'hFFFF_FFFD,  32'h0000_0002, 0);
    run_op("rem_m7_m3",     3'd6, 32'hFFFF_FFF9,  32'hFFFF_FFFD,  32'hFFFF_FFFF, 1);
    run_op("divu_by0",      3'd5, 32'd100,        32'd0,          32'hFFFF_FFFF, 0);
    run_op("remu_by0",      3'd7, 32'd100,        32'd0,          32'h0000_0064, 0);
    run_op("div_ovf",       3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 0);
    run_op("rem_ovf",       3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 0);
    run_op("divu_restart",  3'd5, 32'd100,        32'd7,          32'd14,        2);

    // Reset in the middle of a divide aborts it without a done pulse.
    @(negedge clk);
    start  = 1'b1;
    funct3 = 3'd5;
    op1    = 32'd100;
    op2    = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    chk("abort result", result, 32'd0);
    rst  = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy || done) seen++;
    end
    chk("abort no_activity", 32'(seen), 32'd0);

    // Reset and start together: the start is lost.
    run_op("pre_rst_start", 3'd0, 32'd3, 32'd5, 32'd15, 0);
    @(negedge clk);
    rst    = 1'b1;
    start  = 1'b1;
    funct3 = 3'd4;
    op1    = 32'd50;
    op2    = 32'd5;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_start result", result, 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy || done) seen++;
    end
    chk("rst_start no_activity", 32'(seen), 32'd0);

    for (int i = 0; i < 250; i++) begin
      f = 3'($urandom);
      a = pick_operand();
      b = pick_operand();
      run_op($sformatf("rand%0d_f%0d_%h_%h", i, f, a, b), f, a, b, ref_op(f, a, b),
             int'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
